// File: rtl/imem_loader.sv
// imem_loader: receives a program over a byte stream and writes it into instruction memory
// while holding the CPU in reset.
//
// Stream: N[7:0], N[15:8], 4*N payload bytes (little-endian words), one XOR checksum byte.
//
// Ports:
//   clk           clock; all state changes on the rising edge
//   rst           asynchronous active-high reset
//   start_i       one-cycle load request (honoured in idle, done and error)
//   byte_valid_i  upstream byte valid
//   byte_data_i   upstream byte
//   byte_ready_o  loader accepts a byte this cycle
//   addr_o        imem byte address (word aligned)
//   wr_data_o     imem write data
//   wr_en_o       imem write enable, one cycle per word
//   words_o       words written during the current load
//   busy_o        load in progress
//   done_o        load completed with a matching checksum
//   err_o         load failed (oversized header or checksum mismatch)
//   cpu_hold_o    CPU held in reset; loader owns the imem address port
module imem_loader #(
  parameter int unsigned DEPTH     = 1024,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic        byte_valid_i,
  input  logic [7:0]  byte_data_i,
  output logic        byte_ready_o,
  output logic [31:0] addr_o,
  output logic [31:0] wr_data_o,
  output logic        wr_en_o,
  output logic [10:0] words_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o,
  output logic        cpu_hold_o
);

  typedef enum logic [2:0] {
    StIdle,
    StHdr0,
    StHdr1,
    StLoad,
    StCheck,
    StDone,
    StError
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] n_q, n_d;
  logic [1:0]  byte_idx_q, byte_idx_d;
  logic [23:0] word_buf_q, word_buf_d;
  logic [10:0] words_q, words_d;
  logic [7:0]  csum_q, csum_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        wr_en_q, wr_en_d;

  logic        xfer;
  logic [15:0] n_full;
  logic        last_word;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      n_q        <= '0;
      byte_idx_q <= '0;
      word_buf_q <= '0;
      words_q    <= '0;
      csum_q     <= '0;
      addr_q     <= BASE_ADDR;
      wdata_q    <= '0;
      wr_en_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      n_q        <= n_d;
      byte_idx_q <= byte_idx_d;
      word_buf_q <= word_buf_d;
      words_q    <= words_d;
      csum_q     <= csum_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      wr_en_q    <= wr_en_d;
    end
  end

  // Moore-style handshake: ready depends only on the state.
  always_comb begin
    byte_ready_o = 1'b0;
    unique case (state_q)
      StHdr0, StHdr1, StLoad, StCheck: byte_ready_o = 1'b1;
      default:                         byte_ready_o = 1'b0;
    endcase
  end

  assign xfer      = byte_valid_i && byte_ready_o;
  assign n_full    = {byte_data_i, n_q[7:0]};
  // Word being completed now is the last one of the program.
  assign last_word = ({5'b0, words_q} + 16'd1) == n_q;

  always_comb begin
    state_d    = state_q;
    n_d        = n_q;
    byte_idx_d = byte_idx_q;
    word_buf_d = word_buf_q;
    words_d    = words_q;
    csum_d     = csum_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    wr_en_d    = 1'b0;

    unique case (state_q)
      StIdle, StDone, StError: begin
        if (start_i) begin
          state_d    = StHdr0;
          words_d    = '0;
          csum_d     = '0;
          byte_idx_d = '0;
        end
      end
      StHdr0: begin
        if (xfer) begin
          n_d[7:0] = byte_data_i;
          state_d  = StHdr1;
        end
      end
      StHdr1: begin
        if (xfer) begin
          n_d = n_full;
          if (32'(n_full) > DEPTH) begin
            state_d = StError;
          end else if (n_full == 16'd0) begin
            state_d = StCheck;
          end else begin
            state_d = StLoad;
          end
        end
      end
      StLoad: begin
        if (xfer) begin
          csum_d     = csum_q ^ byte_data_i;
          byte_idx_d = byte_idx_q + 2'd1;
          unique case (byte_idx_q)
            2'd0: word_buf_d[7:0]   = byte_data_i;
            2'd1: word_buf_d[15:8]  = byte_data_i;
            2'd2: word_buf_d[23:16] = byte_data_i;
            default: begin
              wdata_d = {byte_data_i, word_buf_q};
              addr_d  = BASE_ADDR + {19'b0, words_q, 2'b00};
              wr_en_d = 1'b1;
              words_d = words_q + 11'd1;
              if (last_word) begin
                state_d = StCheck;
              end
            end
          endcase
        end
      end
      StCheck: begin
        if (xfer) begin
          state_d = (byte_data_i == csum_q) ? StDone : StError;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign addr_o     = addr_q;
  assign wr_data_o  = wdata_q;
  assign wr_en_o    = wr_en_q;
  assign words_o    = words_q;
  assign busy_o     = byte_ready_o;
  assign done_o     = (state_q == StDone);
  assign err_o      = (state_q == StError);
  assign cpu_hold_o = (state_q != StDone);

endmodule
